// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ctrl_pkg                                                  |
// | Brief    : Shared types and constants for the LFSR-ISA control       |
// |            sequencer (states, opcodes, ACK word helper).             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ctrl_pkg;

    // Sequencer states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        LDW   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Top three instruction bits
    localparam logic [2:0] OP_LDR = 3'b100;
    localparam logic [2:0] OP_STR = 3'b101;
    localparam logic [2:0] OP_BR  = 3'b011;
    localparam logic [2:0] OP_NOP = 3'b110;
    localparam logic [2:0] OP_PAR = 3'b111;

    // The ACK word is the all-ones instruction of the given width
    function automatic logic [31:0] ack_word(input int unsigned iw);
        if (iw >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << iw) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ctrl_decode                                               |
// | Brief    : Purely combinational opcode decode producing raw,         |
// |            ungated instruction class flags.                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int IW = 9
) (
    input  logic [IW-1:0] i_instr,
    output logic          o_ldr,
    output logic          o_str,
    output logic          o_br,
    output logic          o_ack,
    output logic          o_par,
    output logic          o_alu_wr
);

    localparam logic [IW-1:0] c_ack = IW'(ack_word(IW));

    logic [2:0] w_op;
    logic       w_nop;

    assign w_op  = i_instr[IW-1 -: 3];
    assign o_ack = (i_instr == c_ack);
    assign o_ldr = (w_op == OP_LDR);
    assign o_str = (w_op == OP_STR);
    assign o_br  = (w_op == OP_BR);
    assign w_nop = (w_op == OP_NOP);

    // ACK shares the PAR opcode and equal fields, so it must be excluded
    assign o_par = (w_op == OP_PAR) && (i_instr[5:3] == i_instr[2:0]) && !o_ack;

    // Everything that is not a load/store/branch/nop/ack writes the register file
    assign o_alu_wr = !(o_ldr || o_str || o_br || w_nop || o_ack);

endmodule
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ctrl_seq                                                  |
// | Brief    : Stateful control sequencer: gates decoded enables by      |
// |            state, sequences multi-cycle loads, branch flush bubble,  |
// |            program start/done, and counts busy cycles.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int IW       = 9,
    parameter int DW       = 8,
    parameter int TW       = 4,
    parameter int LD_LAT   = 1,
    parameter int BR_COND  = 1,
    parameter int BR_BUB   = 1,
    parameter int TAP_ADDR = 62,
    parameter int CW       = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [IW-1:0] Instruction,
    input  logic [DW-1:0] DatMemAddr,
    input  logic          Zero,
    output logic          RegWrEn,
    output logic          MemWrEn,
    output logic          LoadInst,
    output logic          TapSel,
    output logic          ParityCheck,
    output logic          Branch,
    output logic [TW-1:0] PCTarg,
    output logic          PcStall,
    output logic          Ack,
    output logic          Busy,
    output logic [CW-1:0] CycleCnt
);

    localparam bit            c_multi_ld = (LD_LAT != 0);
    localparam bit            c_bubble   = (BR_BUB != 0);
    localparam logic [2:0]    c_ld_init  = (LD_LAT == 0) ? 3'd0 : 3'(LD_LAT - 1);
    localparam logic [DW-1:0] c_tap      = DW'(TAP_ADDR);
    localparam logic [CW-1:0] c_cnt_max  = '1;

    state_e        r_state;
    state_e        w_state_next;
    logic [2:0]    r_ldcnt;
    logic [CW-1:0] r_cnt;

    logic w_ldr, w_str, w_br, w_ack, w_par, w_alu_wr;
    logic w_taken;
    logic w_busy;
    logic w_idle_or_done;

    ctrl_decode #(
        .IW (IW)
    ) u_decode (
        .i_instr  (Instruction),
        .o_ldr    (w_ldr),
        .o_str    (w_str),
        .o_br     (w_br),
        .o_ack    (w_ack),
        .o_par    (w_par),
        .o_alu_wr (w_alu_wr)
    );

    // Zero only matters in the RUN cycle that decodes the branch
    assign w_taken        = (BR_COND != 0) ? !Zero : 1'b1;
    assign w_busy         = (r_state == RUN) || (r_state == LDW) || (r_state == FLUSH);
    assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; Start is only honoured from IDLE or DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (Start) w_state_next = RUN;
            end
            RUN: begin
                if (w_ldr && c_multi_ld)              w_state_next = LDW;
                else if (w_br && w_taken && c_bubble) w_state_next = FLUSH;
                else if (w_ack)                       w_state_next = DONE;
            end
            LDW: begin
                if (r_ldcnt == 3'd0) w_state_next = RUN;
            end
            FLUSH: begin
                w_state_next = RUN;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output decode gated by state; everything is low outside RUN/LDW except Ack in DONE
    always_comb begin
        RegWrEn     = 1'b0;
        MemWrEn     = 1'b0;
        LoadInst    = 1'b0;
        ParityCheck = 1'b0;
        Branch      = 1'b0;
        PCTarg      = '0;
        PcStall     = 1'b0;
        Ack         = 1'b0;
        case (r_state)
            RUN: begin
                MemWrEn     = w_str;
                RegWrEn     = w_alu_wr;
                ParityCheck = w_par;
                if (w_ldr) begin
                    LoadInst = 1'b1;
                    // A multi-cycle load stalls fetch and defers the write to its last cycle
                    if (c_multi_ld) PcStall = 1'b1;
                    else            RegWrEn = 1'b1;
                end
                if (w_br && w_taken) begin
                    Branch = 1'b1;
                    PCTarg = Instruction[TW-1:0];
                end
            end
            LDW: begin
                LoadInst = 1'b1;
                if (r_ldcnt != 3'd0) PcStall = 1'b1;
                else                 RegWrEn = 1'b1;
            end
            DONE: begin
                Ack = 1'b1;
            end
            default: begin
            end
        endcase
        TapSel = LoadInst && (DatMemAddr == c_tap);
    end

    // Remaining load-wait cycles, armed when a load is decoded in RUN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ldcnt <= 3'd0;
        end else if ((r_state == RUN) && w_ldr) begin
            r_ldcnt <= c_ld_init;
        end else if ((r_state == LDW) && (r_ldcnt != 3'd0)) begin
            r_ldcnt <= r_ldcnt - 3'd1;
        end
    end

    // Saturating busy-cycle counter, cleared whenever a program (re)starts
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (w_idle_or_done && Start) begin
            r_cnt <= '0;
        end else if (w_busy && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign Busy     = w_busy;
    assign CycleCnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ctrl_seq                                               |
// | Brief    : Self-checking bench for ctrl_seq against a program-level  |
// |            behavioural model, directed scenarios plus random stream. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ctrl_seq;

    localparam int IW     = 9;
    localparam int DW     = 8;
    localparam int TW     = 4;
    localparam int LD_LAT = 2;
    localparam int CW     = 4;
    localparam int TAP    = 62;
    localparam int CMAX   = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Start;
    logic [IW-1:0] Instruction;
    logic [DW-1:0] DatMemAddr;
    logic          Zero;
    logic          RegWrEn, MemWrEn, LoadInst, TapSel, ParityCheck, Branch;
    logic [TW-1:0] PCTarg;
    logic          PcStall, Ack, Busy;
    logic [CW-1:0] CycleCnt;

    // 10 ns clock
    always #5 Clk = ~Clk;

    ctrl_seq #(
        .IW(IW), .DW(DW), .TW(TW), .LD_LAT(LD_LAT), .BR_COND(1), .BR_BUB(1),
        .TAP_ADDR(TAP), .CW(CW)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instruction(Instruction),
        .DatMemAddr(DatMemAddr), .Zero(Zero), .RegWrEn(RegWrEn), .MemWrEn(MemWrEn),
        .LoadInst(LoadInst), .TapSel(TapSel), .ParityCheck(ParityCheck), .Branch(Branch),
        .PCTarg(PCTarg), .PcStall(PcStall), .Ack(Ack), .Busy(Busy), .CycleCnt(CycleCnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Program-level model: running/done flags, pending bubble, cycles left in a load
    bit            m_run     = 1'b0;
    bit            m_done    = 1'b0;
    bit            m_flush   = 1'b0;
    int            m_ld_rem  = 0;
    logic [IW-1:0] m_ld_instr = '0;
    int            m_cyc     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] obs_outs();
        return {RegWrEn, MemWrEn, LoadInst, TapSel, ParityCheck, Branch,
                PCTarg, PcStall, Ack, Busy};
    endfunction

    // One clock: drive inputs, predict outputs from the model, compare on the falling edge
    task automatic step(input logic st, input logic [IW-1:0] ins_in, input logic [DW-1:0] ad,
                        input logic z, input string tag);
        logic [IW-1:0] ins;
        logic e_rw, e_mw, e_ld, e_tap, e_par, e_br, e_ps, e_ack, e_busy;
        logic [TW-1:0] e_pct;
        logic [2:0] op;
        int e_cnt;
        ins = (m_ld_rem > 0) ? m_ld_instr : ins_in;
        Start = st; Instruction = ins; DatMemAddr = ad; Zero = z;
        e_rw = 0; e_mw = 0; e_ld = 0; e_par = 0; e_br = 0; e_ps = 0; e_ack = 0; e_busy = 0;
        e_pct = '0;
        e_cnt = m_cyc;
        op = ins[IW-1 -: 3];
        if (!m_run) begin
            e_ack = m_done;
            if (st) begin
                m_run = 1; m_done = 0; m_cyc = 0;
            end
        end else begin
            e_busy = 1;
            if (m_flush) begin
                m_flush = 0;
            end else if (m_ld_rem > 0 || op == 3'b100) begin
                if (m_ld_rem == 0) begin
                    m_ld_rem = LD_LAT + 1;
                    m_ld_instr = ins;
                end
                e_ld = 1;
                e_ps = (m_ld_rem > 1);
                e_rw = (m_ld_rem == 1);
                m_ld_rem--;
            end else if (ins == 9'h1FF) begin
                m_run = 0; m_done = 1;
            end else begin
                case (op)
                    3'b101: e_mw = 1;
                    3'b011: if (!z) begin e_br = 1; e_pct = ins[TW-1:0]; m_flush = 1; end
                    3'b110: ;
                    3'b111: begin e_rw = 1; e_par = (ins[5:3] == ins[2:0]); end
                    default: e_rw = 1;
                endcase
            end
            m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
        end
        e_tap = e_ld && (ad == DW'(TAP));
        @(negedge Clk);
        check({tag, ".outs"}, 32'(obs_outs()),
              32'({e_rw, e_mw, e_ld, e_tap, e_par, e_br, e_pct, e_ps, e_ack, e_busy}));
        check({tag, ".cnt"}, 32'(CycleCnt), 32'(e_cnt));
        @(posedge Clk);
        #1;
    endtask

    // Asynchronous reset between clock edges; outputs must clear without waiting for a clock
    task automatic reset_check(input string tag);
        #2 Reset_n = 1'b0;
        #1;
        check({tag, ".outs"}, 32'(obs_outs()), 32'd0);
        check({tag, ".cnt"}, 32'(CycleCnt), 32'd0);
        m_run = 0; m_done = 0; m_flush = 0; m_ld_rem = 0; m_cyc = 0;
        @(posedge Clk);
        #1 Reset_n = 1'b1;
    endtask

    localparam logic [IW-1:0] NOP = 9'b110_000_000;
    localparam logic [IW-1:0] STR = 9'b101_000_001;
    localparam logic [IW-1:0] LDR = 9'b100_000_000;
    localparam logic [IW-1:0] ACK = 9'b111_111_111;

    initial begin
        logic [IW-1:0] ri;
        logic [2:0]    f;
        logic [DW-1:0] ra;
        Reset_n = 1'b0; Start = 1'b0; Instruction = '0; DatMemAddr = '0; Zero = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("por.outs", 32'(obs_outs()), 32'd0);
        check("por.cnt", 32'(CycleCnt), 32'd0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        // Start, store, then ACK
        step(1, NOP, 8'd0, 0, "start");
        step(0, STR, 8'd0, 0, "str");
        step(0, ACK, 8'd0, 0, "ack1");
        step(0, NOP, 8'd0, 0, "done1");

        // Multi-cycle loads, tap and non-tap addresses
        step(1, NOP, 8'd0, 0, "restart");
        step(0, LDR, 8'd62, 0, "ld_tap0");
        step(0, NOP, 8'd62, 0, "ld_tap1");
        step(0, NOP, 8'd62, 0, "ld_tap2");
        step(0, LDR, 8'd5, 0, "ld_a0");
        step(0, NOP, 8'd62, 0, "ld_a1");
        step(0, NOP, 8'd7, 0, "ld_a2");

        // Reset in the middle of a load wait
        step(0, LDR, 8'd62, 0, "ldmid0");
        step(0, NOP, 8'd62, 0, "ldmid1");
        reset_check("rst_ldw");
        step(1, NOP, 8'd0, 0, "start2");

        // Taken branch with bubble, then not-taken branch
        step(0, 9'b011_00_0101, 8'd0, 0, "br_t");
        step(0, STR, 8'd0, 0, "flush");
        step(0, 9'b011_00_0101, 8'd0, 1, "br_nt");
        step(0, NOP, 8'd0, 0, "after_br");

        // Parity, ALU op under PAR opcode, ACK, held DONE, restart
        step(0, 9'b111_010_010, 8'd0, 0, "par");
        step(0, 9'b111_010_011, 8'd0, 0, "alu111");
        step(0, 9'b000_101_011, 8'd0, 0, "alu000");
        step(0, ACK, 8'd0, 0, "ack2");
        repeat (3) step(0, NOP, 8'd0, 0, "hold");
        step(1, NOP, 8'd0, 0, "restart3");
        step(0, NOP, 8'd0, 0, "ackdrop");

        // Saturation of the busy counter; Start while running is ignored
        for (int i = 0; i < 20; i++) step(i[0], NOP, 8'd0, 0, "sat");
        step(0, ACK, 8'd0, 0, "ack3");
        step(0, NOP, 8'd0, 0, "done3");
        step(1, NOP, 8'd0, 0, "restart4");
        step(0, NOP, 8'd0, 0, "cnt_clr");

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset_check("rnd_rst");
            end else begin
                case ($urandom_range(0, 15))
                    0:       ri = ACK;
                    1:       begin f = 3'($urandom); ri = {3'b111, f, f}; end
                    2:       ri = {3'b011, 6'($urandom)};
                    default: ri = 9'($urandom);
                endcase
                ra = ($urandom_range(0, 1) == 1) ? 8'd62 : 8'($urandom);
                step(($urandom_range(0, 3) == 0), ri, ra, 1'($urandom), "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
